// File: rtl/key_bytes_to_words.sv
// key_bytes_to_words: RC5 key-expansion front end.
// Walks the key byte memory K from the top byte down to byte 0 and builds the
// L word array in an external word memory by read-modify-write:
//     L[i/u] = (L[i/u] << 8) + K[i]
// A CLEAR pass zeroes L first, so the previous memory contents never matter.
// The sequence runs once after reset release and then parks in DONE.
module key_bytes_to_words #(
    parameter int w        = 32,
    parameter int u        = 4,
    parameter int b        = 16,
    parameter int b_length = 4,
    parameter int c        = 4,
    parameter int c_length = 2
) (
    input  logic                clk1,
    input  logic                rst,
    input  logic [7:0]          key_sub_i,
    input  logic [w-1:0]        L_sub_i,
    output logic [b_length-1:0] key_address,
    output logic [c_length-1:0] L_address,
    output logic [w-1:0]        L_sub_i_prima,
    output logic                L_write_en,
    output logic                done
);

    localparam int CNT_W = (b_length > c_length) ? b_length : c_length;
    localparam int U_LOG = $clog2(u);

    localparam logic [CNT_W-1:0]    CNT_CLEAR_LAST = CNT_W'(c - 1);
    localparam logic [CNT_W-1:0]    CNT_LOAD_LAST  = CNT_W'(b - 1);
    localparam logic [b_length-1:0] KEY_TOP        = b_length'(b - 1);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_LOAD  = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    // Byte being merged during LOAD counts down from the top of the key,
    // and the word it belongs to is simply that index divided by u.
    logic [CNT_W-1:0] w_byte_idx;
    logic [CNT_W-1:0] w_word_idx;

    assign w_byte_idx = CNT_LOAD_LAST - r_cnt;
    assign w_word_idx = w_byte_idx >> U_LOG;

    // Top byte of the old word is shifted out, and the index wires are wider
    // than the addresses they feed; fold the leftover bits away explicitly.
    logic w_unused_bits;
    assign w_unused_bits = ^{L_sub_i[w-1:w-8], w_word_idx, w_byte_idx};

    // State and counter register; reset aborts any pass and restarts CLEAR.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic: CLEAR for c cycles, LOAD for b cycles, then DONE forever.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_CLEAR: begin
                if (r_cnt == CNT_CLEAR_LAST) begin
                    w_state_next = S_LOAD;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_LOAD: begin
                if (r_cnt == CNT_LOAD_LAST) begin
                    w_state_next = S_DONE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = S_DONE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Output decode: purely combinational from state, counter and read data.
    always_comb begin
        key_address   = '0;
        L_address     = '0;
        L_sub_i_prima = '0;
        L_write_en    = 1'b0;
        done          = 1'b0;
        case (r_state)
            S_CLEAR: begin
                key_address = KEY_TOP;
                L_address   = r_cnt[c_length-1:0];
                L_write_en  = 1'b1;
            end
            S_LOAD: begin
                key_address   = w_byte_idx[b_length-1:0];
                L_address     = w_word_idx[c_length-1:0];
                L_sub_i_prima = {L_sub_i[w-9:0], key_sub_i};
                L_write_en    = 1'b1;
            end
            default: begin
                done = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_key_bytes_to_words.sv
// Self-checking bench for key_bytes_to_words.
// Provides behavioural key/L memories (combinational read, edge write, no
// writes while reset is low) and compares every cycle's addresses, enables and
// write data, plus the final L contents, against values computed directly
// from the byte-to-word packing rule.
module tb_key_bytes_to_words;

    localparam int W = 32;
    localparam int U = 4;
    localparam int B = 16;
    localparam int C = 4;
    localparam int LATENCY = C + B;

    logic        clk1 = 1'b0;
    logic        rst  = 1'b0;
    logic [7:0]  key_sub_i;
    logic [31:0] L_sub_i;
    logic [3:0]  key_address;
    logic [1:0]  L_address;
    logic [31:0] L_sub_i_prima;
    logic        L_write_en;
    logic        done;

    logic [7:0]  key_mem [B];
    logic [31:0] L_mem   [C];
    logic [31:0] exp_L   [C];
    logic        preload_en  = 1'b0;
    logic [31:0] preload_val = 32'h0;

    int n_vectors     = 0;
    int n_miscompares = 0;

    key_bytes_to_words #(
        .w(W), .u(U), .b(B), .b_length(4), .c(C), .c_length(2)
    ) dut (
        .clk1          (clk1),
        .rst           (rst),
        .key_sub_i     (key_sub_i),
        .L_sub_i       (L_sub_i),
        .key_address   (key_address),
        .L_address     (L_address),
        .L_sub_i_prima (L_sub_i_prima),
        .L_write_en    (L_write_en),
        .done          (done)
    );

    always #5 clk1 = ~clk1;

    assign key_sub_i = key_mem[key_address];
    assign L_sub_i   = L_mem[L_address];

    // L memory: preload port for the bench, otherwise the DUT's write port.
    always @(posedge clk1) begin
        if (preload_en) begin
            for (int j = 0; j < C; j++) L_mem[j] <= preload_val;
        end else if (rst && L_write_en) begin
            L_mem[L_address] <= L_sub_i_prima;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Expected L: word j packs K[4j] in the low byte up to K[4j+3] on top.
    task automatic compute_expected();
        for (int j = 0; j < C; j++) begin
            exp_L[j] = 32'h0;
            for (int k = 0; k < U; k++)
                exp_L[j] = exp_L[j] | (32'(key_mem[U*j+k]) << (8*k));
        end
    endtask

    // Value of the partially built word right after byte i is merged:
    // bytes K[i..top of word] with K[i] in the low byte.
    function automatic logic [31:0] partial_word(input int i);
        logic [31:0] acc;
        int top;
        acc = 32'h0;
        top = (i / U) * U + U - 1;
        for (int k = i; k <= top; k++)
            acc = acc | (32'(key_mem[k]) << (8*(k-i)));
        return acc;
    endfunction

    // Hold reset for two edges while scribbling the L memory, leave at a negedge.
    task automatic enter_reset(input logic [31:0] fill);
        @(negedge clk1);
        rst         = 1'b0;
        preload_en  = 1'b1;
        preload_val = fill;
        @(negedge clk1);
        @(negedge clk1);
        preload_en  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        #1;
        check_value({tag, ".key_address"}, 32'(key_address), 32'(B-1));
        check_value({tag, ".L_address"},   32'(L_address),   32'd0);
        check_value({tag, ".L_write_en"},  32'(L_write_en),  32'd1);
        check_value({tag, ".L_prima"},     L_sub_i_prima,    32'd0);
        check_value({tag, ".done"},        32'(done),        32'd0);
    endtask

    // Release reset (called at a negedge), check all LATENCY working cycles,
    // then check the DONE outputs and the L memory contents.
    task automatic run_and_check(input string tag);
        int i;
        compute_expected();
        rst = 1'b1;
        for (int n = 0; n < LATENCY; n++) begin
            #1;
            if (n < C) begin
                check_value({tag, ".clr_key_addr"}, 32'(key_address), 32'(B-1));
                check_value({tag, ".clr_L_addr"},   32'(L_address),   32'(n));
                check_value({tag, ".clr_prima"},    L_sub_i_prima,    32'd0);
            end else begin
                i = B - 1 - (n - C);
                check_value({tag, ".ld_key_addr"}, 32'(key_address), 32'(i));
                check_value({tag, ".ld_L_addr"},   32'(L_address),   32'(i / U));
                check_value({tag, ".ld_prima"},    L_sub_i_prima,    partial_word(i));
            end
            check_value({tag, ".we_busy"},   32'(L_write_en), 32'd1);
            check_value({tag, ".done_busy"}, 32'(done),       32'd0);
            @(negedge clk1);
        end
        #1;
        check_value({tag, ".done"},          32'(done),        32'd1);
        check_value({tag, ".we_done"},       32'(L_write_en),  32'd0);
        check_value({tag, ".key_addr_done"}, 32'(key_address), 32'd0);
        check_value({tag, ".L_addr_done"},   32'(L_address),   32'd0);
        check_value({tag, ".prima_done"},    L_sub_i_prima,    32'd0);
        for (int j = 0; j < C; j++)
            check_value({tag, ".L", $sformatf("%0d", j)}, L_mem[j], exp_L[j]);
        $display("run %s: L = %08h %08h %08h %08h", tag, L_mem[0], L_mem[1], L_mem[2], L_mem[3]);
    endtask

    initial begin
        logic [127:0] const_key;

        // Reset values with the incrementing key.
        for (int i = 0; i < B; i++) key_mem[i] = 8'(5 + i);
        enter_reset(32'hDEADBEEF);
        check_reset_outputs("reset");
        @(negedge clk1);

        // Full run, incrementing key, preloaded with DEADBEEF.
        run_and_check("incr");
        check_value("incr.L0_abs", L_mem[0], 32'h08070605);
        check_value("incr.L3_abs", L_mem[3], 32'h14131211);

        // Hold in DONE for 50 more cycles.
        for (int n = 0; n < 50; n++) begin
            @(negedge clk1);
            #1;
            check_value("hold.done", 32'(done),       32'd1);
            check_value("hold.we",   32'(L_write_en), 32'd0);
        end
        for (int j = 0; j < C; j++)
            check_value("hold.L", L_mem[j], exp_L[j]);

        // Constant key, K[0] is the least significant byte.
        const_key = 128'hFFFEEEE58684FFF05FFE493853000434;
        for (int i = 0; i < B; i++) key_mem[i] = const_key[8*i +: 8];
        enter_reset(32'h12345678);
        check_reset_outputs("const_rst");
        run_and_check("const");
        check_value("const.L0_abs", L_mem[0], 32'h53000434);
        check_value("const.L1_abs", L_mem[1], 32'h5FFE4938);
        check_value("const.L2_abs", L_mem[2], 32'h8684FFF0);
        check_value("const.L3_abs", L_mem[3], 32'hFFFEEEE5);

        // Mid-run reset at LOAD cnt = 7, then a complete clean run.
        for (int i = 0; i < B; i++) key_mem[i] = 8'($urandom);
        enter_reset(32'hDEADBEEF);
        rst = 1'b1;
        for (int n = 0; n < C + 7; n++) @(negedge clk1);
        rst = 1'b0;
        check_reset_outputs("midrst");
        @(negedge clk1);
        run_and_check("midrun");

        // Randomised keys and random stale memory contents.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < B; i++) key_mem[i] = 8'($urandom);
            enter_reset($urandom);
            run_and_check($sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
